// File: rtl/posicionador_de_navios.sv
// Ship placement writer for the 5x7 naval grid: bounds/overlap check, map OR-in.
// Optional live preview outputs enabled by POSICIONADOR_PREVIA_EN.
module posicionador_de_navios #(
    parameter int TAM_NAVIO0 = 3,
    parameter int TAM_NAVIO1 = 2,
    parameter int TAM_NAVIO2 = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] coordColuna,
    input  logic [2:0] coordLinha,
    input  logic       orientacao,
    input  logic       confirmar,
    output logic [6:0] mapa0,
    output logic [6:0] mapa1,
    output logic [6:0] mapa2,
    output logic [6:0] mapa3,
    output logic [6:0] mapa4,
    output logic [1:0] navio_atual,
    output logic       pronto,
`ifdef POSICIONADOR_PREVIA_EN
    output logic [6:0] previa0,
    output logic [6:0] previa1,
    output logic [6:0] previa2,
    output logic [6:0] previa3,
    output logic [6:0] previa4,
`endif
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO,
        POSICIONA,
        VERIFICA,
        PRONTO
    } estado_t;

    typedef logic [4:0][6:0] grade_t;

    estado_t    estado_q, estado_d;
    grade_t     mapa_q, mapa_d;
    logic [1:0] navio_q, navio_d;
    logic       pronto_q, pronto_d;
    logic       erro_q, erro_d;
    logic       conf_q, conf_d;
    logic       captura;
    logic [2:0] col_q, lin_q;
    logic       ori_q;
    logic [2:0] tam;
    grade_t     mascara;
    logic       valido;

    function automatic grade_t gera_mascara(input logic [2:0] c,
                                            input logic [2:0] l,
                                            input logic       o,
                                            input logic [2:0] t);
        grade_t     m;
        logic [3:0] cc, ll, fc, fl;
        cc = {1'b0, c};
        ll = {1'b0, l};
        fc = cc + {1'b0, t} - 4'd1;
        fl = ll + {1'b0, t} - 4'd1;
        m  = '0;
        for (int ci = 0; ci < 5; ci++) begin
            for (int li = 0; li < 7; li++) begin
                if (o)
                    m[ci][li] = (4'(ci) == cc) && (4'(li) >= ll) && (4'(li) <= fl);
                else
                    m[ci][li] = (4'(li) == ll) && (4'(ci) >= cc) && (4'(ci) <= fc);
            end
        end
        return m;
    endfunction

    // Sums are 4 bits wide so a 3-bit coordinate plus length cannot wrap.
    function automatic logic cabe(input logic [2:0] c,
                                  input logic [2:0] l,
                                  input logic       o,
                                  input logic [2:0] t);
        logic [3:0] fc, fl;
        fc = {1'b0, c} + {1'b0, t} - 4'd1;
        fl = {1'b0, l} + {1'b0, t} - 4'd1;
        return (c <= 3'd4) && (l <= 3'd6) &&
               (o ? (fl <= 4'd6) : (fc <= 4'd4));
    endfunction

    always_comb begin
        tam = 3'd1;
        unique case (navio_q)
            2'd0:    tam = 3'(TAM_NAVIO0);
            2'd1:    tam = 3'(TAM_NAVIO1);
            2'd2:    tam = 3'(TAM_NAVIO2);
            default: tam = 3'd1;
        endcase
    end

    assign mascara = gera_mascara(col_q, lin_q, ori_q, tam);
    assign valido  = cabe(col_q, lin_q, ori_q, tam) && ((mascara & mapa_q) == '0);

    always_comb begin
        estado_d = estado_q;
        mapa_d   = mapa_q;
        navio_d  = navio_q;
        pronto_d = pronto_q;
        erro_d   = erro_q;
        conf_d   = confirmar;
        captura  = 1'b0;
        if (!enable) begin
            estado_d = OCIOSO;
            mapa_d   = '0;
            navio_d  = 2'd0;
            pronto_d = 1'b0;
            erro_d   = 1'b0;
            conf_d   = 1'b0;
        end else begin
            unique case (estado_q)
                OCIOSO: estado_d = POSICIONA;
                POSICIONA: begin
                    if (confirmar && !conf_q) begin
                        captura  = 1'b1;
                        estado_d = VERIFICA;
                    end
                end
                VERIFICA: begin
                    estado_d = POSICIONA;
                    if (valido) begin
                        mapa_d  = mapa_q | mascara;
                        erro_d  = 1'b0;
                        navio_d = navio_q + 2'd1;
                        if (navio_q == 2'd2) begin
                            estado_d = PRONTO;
                            pronto_d = 1'b1;
                        end
                    end else begin
                        erro_d = 1'b1;
                    end
                end
                PRONTO: begin
                    pronto_d = 1'b1;
                    navio_d  = 2'd3;
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            mapa_q   <= '0;
            navio_q  <= 2'd0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
            conf_q   <= 1'b0;
            col_q    <= 3'd0;
            lin_q    <= 3'd0;
            ori_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            mapa_q   <= mapa_d;
            navio_q  <= navio_d;
            pronto_q <= pronto_d;
            erro_q   <= erro_d;
            conf_q   <= conf_d;
            if (captura) begin
                col_q <= coordColuna;
                lin_q <= coordLinha;
                ori_q <= orientacao;
            end
        end
    end

    assign mapa0       = mapa_q[0];
    assign mapa1       = mapa_q[1];
    assign mapa2       = mapa_q[2];
    assign mapa3       = mapa_q[3];
    assign mapa4       = mapa_q[4];
    assign navio_atual = navio_q;
    assign pronto      = pronto_q;
    assign erro        = erro_q;

`ifdef POSICIONADOR_PREVIA_EN
    grade_t previa_q, previa_d;

    // Preview ignores overlap on purpose: the player sees where the ship would land.
    always_comb begin
        previa_d = '0;
        if (enable && estado_q == POSICIONA &&
            cabe(coordColuna, coordLinha, orientacao, tam))
            previa_d = gera_mascara(coordColuna, coordLinha, orientacao, tam);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) previa_q <= '0;
        else        previa_q <= previa_d;
    end

    assign previa0 = previa_q[0];
    assign previa1 = previa_q[1];
    assign previa2 = previa_q[2];
    assign previa3 = previa_q[3];
    assign previa4 = previa_q[4];
`endif

endmodule

// File: tb/tb_posicionador_de_navios.sv
// Directed-vector bench for posicionador_de_navios (default ship sizes 3,2,1).
module tb_posicionador_de_navios;

    logic       clk = 1'b0;
    logic       rst_n, enable, ori, conf;
    logic [2:0] col, lin;
    logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
    logic [1:0] navio_atual;
    logic       pronto, erro;
`ifdef POSICIONADOR_PREVIA_EN
    logic [6:0] previa0, previa1, previa2, previa3, previa4;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    posicionador_de_navios dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .coordColuna(col), .coordLinha(lin), .orientacao(ori),
        .confirmar(conf),
        .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2),
        .mapa3(mapa3), .mapa4(mapa4),
        .navio_atual(navio_atual), .pronto(pronto),
`ifdef POSICIONADOR_PREVIA_EN
        .previa0(previa0), .previa1(previa1), .previa2(previa2),
        .previa3(previa3), .previa4(previa4),
`endif
        .erro(erro)
    );

    typedef struct {
        logic [2:0]  c;
        logic [2:0]  l;
        logic        o;
        logic [34:0] m;
        logic [1:0]  nav;
        logic        err;
        logic        pr;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [34:0] mk(input logic [6:0] m0, m1, m2, m3, m4);
        return {m4, m3, m2, m1, m0};
    endfunction

    function automatic logic [34:0] maps();
        return {mapa4, mapa3, mapa2, mapa1, mapa0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic check_all(input string nm, input vec_t e);
        chk({nm, "_maps"}, 64'(maps()), 64'(e.m));
        chk({nm, "_nav"}, 64'(navio_atual), 64'(e.nav));
        chk({nm, "_erro"}, 64'(erro), 64'(e.err));
        chk({nm, "_pronto"}, 64'(pronto), 64'(e.pr));
    endtask

    task automatic place(input string nm, input vec_t e, input logic [34:0] prev);
        @(negedge clk);
        col = e.c; lin = e.l; ori = e.o; conf = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_hold"}, 64'(maps()), 64'(prev));
        @(negedge clk);
        conf = 1'b0; col = 3'd1; lin = 3'd1; ori = ~e.o;
        @(posedge clk); #1;
        check_all(nm, e);
    endtask

    task automatic limpa();
        @(negedge clk); enable = 1'b0; conf = 1'b0;
        @(negedge clk); enable = 1'b1;
        @(posedge clk);
    endtask

    vec_t        v;
    logic [34:0] prev;

    initial begin
        vecs[0] = '{3'd0, 3'd0, 1'b0, mk(7'h01, 7'h01, 7'h01, 7'h00, 7'h00), 2'd1, 1'b0, 1'b0};
        vecs[1] = '{3'd0, 3'd0, 1'b1, mk(7'h01, 7'h01, 7'h01, 7'h00, 7'h00), 2'd1, 1'b1, 1'b0};
        vecs[2] = '{3'd4, 3'd1, 1'b0, mk(7'h01, 7'h01, 7'h01, 7'h00, 7'h00), 2'd1, 1'b1, 1'b0};
        vecs[3] = '{3'd5, 3'd0, 1'b0, mk(7'h01, 7'h01, 7'h01, 7'h00, 7'h00), 2'd1, 1'b1, 1'b0};
        vecs[4] = '{3'd0, 3'd7, 1'b0, mk(7'h01, 7'h01, 7'h01, 7'h00, 7'h00), 2'd1, 1'b1, 1'b0};
        vecs[5] = '{3'd4, 3'd5, 1'b1, mk(7'h01, 7'h01, 7'h01, 7'h00, 7'h60), 2'd2, 1'b0, 1'b0};
        vecs[6] = '{3'd2, 3'd3, 1'b0, mk(7'h01, 7'h01, 7'h09, 7'h00, 7'h60), 2'd3, 1'b0, 1'b1};
        vecs[7] = '{3'd0, 3'd6, 1'b0, mk(7'h01, 7'h01, 7'h09, 7'h00, 7'h60), 2'd3, 1'b0, 1'b1};

        rst_n = 1'b0; enable = 1'b0; conf = 1'b0;
        col = 3'd0; lin = 3'd0; ori = 1'b0;
        #2;
        v = '{3'd0, 3'd0, 1'b0, 35'd0, 2'd0, 1'b0, 1'b0};
        check_all("reset", v);
        @(negedge clk); rst_n = 1'b1; enable = 1'b1;
        @(posedge clk);

        prev = '0;
        for (int i = 0; i < 8; i++) begin
            place($sformatf("vec%0d", i), vecs[i], prev);
            prev = vecs[i].m;
        end

        // Asynchronous reset while in the complete state.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        v = '{3'd0, 3'd0, 1'b0, 35'd0, 2'd0, 1'b0, 1'b0};
        check_all("rst_mid", v);
        @(negedge clk); rst_n = 1'b1; enable = 1'b1;
        @(posedge clk);
        place("after_rst", vecs[0], 35'd0);

        // Held confirm must trigger once; cursor moves to a spot that would be valid.
        limpa();
        @(negedge clk); col = 3'd0; lin = 3'd0; ori = 1'b0; conf = 1'b1;
        @(posedge clk);
        @(negedge clk); col = 3'd0; lin = 3'd3;
        repeat (4) @(posedge clk);
        @(negedge clk); conf = 1'b0;
        @(posedge clk); #1;
        check_all("hold5", vecs[0]);

        // Enable low on the write edge wins.
        limpa();
        @(negedge clk); col = 3'd0; lin = 3'd0; ori = 1'b0; conf = 1'b1;
        @(posedge clk);
        @(negedge clk); conf = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        v = '{3'd0, 3'd0, 1'b0, 35'd0, 2'd0, 1'b0, 1'b0};
        check_all("en_prio", v);
        @(negedge clk); enable = 1'b1; conf = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        check_all("idle_drop", v);
        @(negedge clk); conf = 1'b0;
        place("after_en", vecs[0], 35'd0);

`ifdef POSICIONADOR_PREVIA_EN
        limpa();
        @(negedge clk); col = 3'd1; lin = 3'd2; ori = 1'b0;
        @(posedge clk); #1;
        chk("previa", 64'({previa4, previa3, previa2, previa1, previa0}),
            64'(mk(7'h00, 7'h04, 7'h04, 7'h04, 7'h00)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
